// File: rtl/flex_stp_pkg.sv
// Shared types and helpers for the flex_stp deserializer: holding-register state,
// beat-count arithmetic and the even-parity check used when FLEX_STP_PARITY_EN is defined.
package flex_stp_pkg;

  typedef enum logic {HOLD_EMPTY, HOLD_FULL} hold_state_e;

  // Widest word the parity helper can cover.
  localparam int unsigned PAR_MAX_BITS = 64;

  function automatic int unsigned calc_beats(input int unsigned num_bits,
                                             input int unsigned num_lanes);
    return num_bits / num_lanes;
  endfunction

  // Returns 1 when word plus parity bit has odd weight, i.e. even parity is violated.
  function automatic logic word_parity(input logic [PAR_MAX_BITS-1:0] word,
                                       input logic                    pbit);
    return (^word) ^ pbit;
  endfunction

endpackage

// File: rtl/flex_stp_beat_ctr.sv
// Wrap counter 0..MODULUS-1 with synchronous clear (priority over enable),
// enable, and a terminal-count flag that is high while the count sits at MODULUS-1.
module flex_stp_beat_ctr #(
  parameter int unsigned MODULUS = 8,
  parameter int unsigned WIDTH   = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;

  assign tc_o    = (count_q == LAST);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = tc_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/flex_stp_deser.sv
// Multi-lane serial-to-parallel deserializer with word framing, one-word holding register
// and valid/ready output. FLEX_STP_PARITY_EN adds a trailing parity beat and parity_err.
module flex_stp_deser
  import flex_stp_pkg::*;
#(
  parameter int unsigned NUM_BITS  = 8,
  parameter int unsigned NUM_LANES = 1,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 shift_enable,
  input  logic [NUM_LANES-1:0] serial_in,
  input  logic                 word_ready,
  output logic [NUM_BITS-1:0]  parallel_out,
  output logic                 word_valid,
  output logic                 overrun,
  output logic [$clog2(calc_beats(NUM_BITS, NUM_LANES)+1)-1:0] beat_count
`ifdef FLEX_STP_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int unsigned BEATS = calc_beats(NUM_BITS, NUM_LANES);
  localparam int unsigned CNT_W = $clog2(BEATS + 1);
`ifdef FLEX_STP_PARITY_EN
  localparam int unsigned MODULUS = BEATS + 1;
`else
  localparam int unsigned MODULUS = BEATS;
`endif

  generate
    if ((NUM_BITS % NUM_LANES) != 0 || NUM_BITS < 2) begin : g_bad_params
      $error("flex_stp_deser: NUM_BITS must be >= 2 and a multiple of NUM_LANES");
    end
`ifdef FLEX_STP_PARITY_EN
    if (NUM_BITS > PAR_MAX_BITS) begin : g_bad_parity_width
      $error("flex_stp_deser: NUM_BITS exceeds parity helper width");
    end
`endif
  endgenerate

  logic [NUM_BITS-1:0] sr_q, sr_d, sr_shifted;
  logic [NUM_BITS-1:0] pout_q, pout_d;
  logic                ovr_q, ovr_d;
  hold_state_e         state_q, state_d;
  logic                cnt_tc;
  logic                beat_ok;
  logic                data_beat;
  logic                complete;
  logic [NUM_BITS-1:0] new_word;
`ifdef FLEX_STP_PARITY_EN
  logic                perr_q, perr_d;
  logic                new_perr;
`endif

  generate
    if (BEATS == 1) begin : g_one_beat
      assign sr_shifted = serial_in;
    end else if (SHIFT_MSB) begin : g_shift_msb
      assign sr_shifted = {sr_q[NUM_BITS-NUM_LANES-1:0], serial_in};
    end else begin : g_shift_lsb
      assign sr_shifted = {serial_in, sr_q[NUM_BITS-1:NUM_LANES]};
    end
  endgenerate

  flex_stp_beat_ctr #(
    .MODULUS (MODULUS),
    .WIDTH   (CNT_W)
  ) u_beat_ctr (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear_i (clear),
    .en_i    (shift_enable),
    .count_o (beat_count),
    .tc_o    (cnt_tc)
  );

  assign beat_ok = shift_enable && !clear;

`ifdef FLEX_STP_PARITY_EN
  // The terminal beat carries parity only; the word is already fully shifted in.
  assign data_beat = beat_ok && !cnt_tc;
  assign complete  = beat_ok && cnt_tc;
  assign new_word  = sr_q;
  assign new_perr  = word_parity(PAR_MAX_BITS'(sr_q), serial_in[0]);
`else
  assign data_beat = beat_ok;
  assign complete  = beat_ok && cnt_tc;
  assign new_word  = sr_shifted;
`endif

  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '1;
    end else if (data_beat) begin
      sr_d = sr_shifted;
    end
  end

  always_comb begin
    state_d = state_q;
    pout_d  = pout_q;
    ovr_d   = ovr_q;
`ifdef FLEX_STP_PARITY_EN
    perr_d  = perr_q;
`endif
    if (clear) begin
      state_d = HOLD_EMPTY;
      ovr_d   = 1'b0;
    end else begin
      case (state_q)
        HOLD_EMPTY: begin
          if (complete) begin
            state_d = HOLD_FULL;
            pout_d  = new_word;
`ifdef FLEX_STP_PARITY_EN
            perr_d  = new_perr;
`endif
          end
        end
        HOLD_FULL: begin
          if (complete && word_ready) begin
            pout_d = new_word;
`ifdef FLEX_STP_PARITY_EN
            perr_d = new_perr;
`endif
          end else if (complete) begin
            // Consumer stalled: keep the held word, drop the new one.
            ovr_d = 1'b1;
          end else if (word_ready) begin
            state_d = HOLD_EMPTY;
          end
        end
        default: state_d = HOLD_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr_q    <= '1;
      pout_q  <= '1;
      ovr_q   <= 1'b0;
      state_q <= HOLD_EMPTY;
`ifdef FLEX_STP_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sr_q    <= sr_d;
      pout_q  <= pout_d;
      ovr_q   <= ovr_d;
      state_q <= state_d;
`ifdef FLEX_STP_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign parallel_out = pout_q;
  assign word_valid   = (state_q == HOLD_FULL);
  assign overrun      = ovr_q;
`ifdef FLEX_STP_PARITY_EN
  assign parity_err   = perr_q;
`endif

endmodule
